// File: rtl/vote_tally_bank_if.sv
// Bus bundle for the vote tally bank: voting controls, readout port and tally/leader status.
interface vote_tally_bank_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + IDX_W;

  logic                mode;
  logic                clear;
  logic [NUM_CAND-1:0] vote_valid;
  logic                vote_ack;
  logic                rd_req;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_valid;
  logic [CNT_W-1:0]    rd_data;
  logic [TOT_W-1:0]    total_votes;
  logic [CNT_W-1:0]    reject_cnt;
  logic [NUM_CAND-1:0] sat_flags;
  logic [IDX_W-1:0]    leader_idx;
  logic                leader_tie;

  modport master (
    output mode, clear, vote_valid, rd_req, rd_idx,
    input  vote_ack, rd_valid, rd_data, total_votes, reject_cnt, sat_flags,
           leader_idx, leader_tie
  );

  modport slave (
    input  mode, clear, vote_valid, rd_req, rd_idx,
    output vote_ack, rd_valid, rd_data, total_votes, reject_cnt, sat_flags,
           leader_idx, leader_tie
  );
endinterface

// File: rtl/vote_tally_bank.sv
// N-candidate vote tally with press lockout, multi-press rejection, saturating counters,
// registered leader/tie status and an indexed readout port usable in results mode.
module vote_tally_bank #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  vote_tally_bank_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt_q [NUM_CAND];
  logic [CNT_W-1:0]    cnt_d [NUM_CAND];
  logic [TOT_W-1:0]    total_q, total_d;
  logic [CNT_W-1:0]    reject_q, reject_d;
  logic [NUM_CAND-1:0] sat_q, sat_d;
  logic                ack_q, ack_d;
  logic                armed_q, armed_d;
  logic                rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]    rd_data_q, rd_data_d;
  logic [IDX_W-1:0]    leader_idx_q, leader_idx_d;
  logic                leader_tie_q, leader_tie_d;
  logic [CNT_W-1:0]    lead_max;
  int                  n_hot;
  int                  n_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Vote evaluation: a press only counts on the first edge after all buttons were released.
  always_comb begin
    cnt_d    = cnt_q;
    total_d  = total_q;
    reject_d = reject_q;
    sat_d    = sat_q;
    ack_d    = 1'b0;
    armed_d  = (bus.vote_valid == '0);
    n_hot    = $countones(bus.vote_valid);
    if (bus.clear) begin
      for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = '0;
      total_d  = '0;
      reject_d = '0;
      sat_d    = '0;
    end else if (!bus.mode && armed_q && n_hot != 0) begin
      if (n_hot > 1) begin
        reject_d = sat_inc(reject_q);
      end else begin
        for (int i = 0; i < NUM_CAND; i++) begin
          if (bus.vote_valid[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
              reject_d = sat_inc(reject_q);
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
              total_d  = total_q + TOT_W'(1);
              ack_d    = 1'b1;
              sat_d[i] = sat_q[i] | (cnt_q[i] == CNT_MAX - CNT_W'(1));
            end
          end
        end
      end
    end
  end

  // Leader is derived from the registered counts, so it trails a count change by one cycle.
  always_comb begin
    lead_max     = cnt_q[0];
    leader_idx_d = '0;
    n_max        = 0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (cnt_q[i] > lead_max) begin
        lead_max     = cnt_q[i];
        leader_idx_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cnt_q[i] == lead_max) n_max = n_max + 1;
    end
    leader_tie_d = (n_max >= 2);
  end

  // Readout samples pre-edge counts; out-of-range indices return zero.
  always_comb begin
    rd_valid_d = bus.rd_req && bus.mode;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        if (bus.rd_idx == IDX_W'(i)) rd_data_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_q      <= '0;
      reject_q     <= '0;
      sat_q        <= '0;
      ack_q        <= 1'b0;
      armed_q      <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      leader_idx_q <= '0;
      leader_tie_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      reject_q     <= reject_d;
      sat_q        <= sat_d;
      ack_q        <= ack_d;
      armed_q      <= armed_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      leader_idx_q <= leader_idx_d;
      leader_tie_q <= leader_tie_d;
    end
  end

  assign bus.vote_ack    = ack_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.total_votes = total_q;
  assign bus.reject_cnt  = reject_q;
  assign bus.sat_flags   = sat_q;
  assign bus.leader_idx  = leader_idx_q;
  assign bus.leader_tie  = leader_tie_q;
endmodule

// File: tb/tb_vote_tally_bank.sv
// Scoreboard bench for vote_tally_bank (5 candidates, 3-bit counters): stimulus queues expected
// acks and readouts, an independent monitor pops them when the DUT presents vote_ack / rd_valid.
module tb_vote_tally_bank;
  localparam int NC = 5;
  localparam int CW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ack_exp[$];
  int   rd_exp[$];

  vote_tally_bank_if #(.NUM_CAND(NC), .CNT_W(CW)) bus();

  vote_tally_bank #(.NUM_CAND(NC), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every ack must match a queued expected total, every rd_valid a queued datum.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.vote_ack) begin
        if (ack_exp.size() == 0) chk("unexpected_ack", 1, 0);
        else chk("ack_total", 32'(bus.total_votes), 32'(ack_exp.pop_front()));
      end
      if (bus.rd_valid) begin
        if (rd_exp.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else chk("rd_data", 32'(bus.rd_data), 32'(rd_exp.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One press cycle followed by one release cycle.
  task automatic press(input logic [NC-1:0] vv, input bit exp_ack, input int exp_total);
    bus.vote_valid = vv;
    if (exp_ack) ack_exp.push_back(exp_total);
    step();
    bus.vote_valid = '0;
    step();
  endtask

  task automatic rd(input logic [2:0] idx, input int exp);
    bus.rd_req = 1'b1;
    bus.rd_idx = idx;
    rd_exp.push_back(exp);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode = 1'b0; bus.clear = 1'b0; bus.vote_valid = '0;
    bus.rd_req = 1'b0; bus.rd_idx = '0;
    step(); step();
    chk("rst_total", 32'(bus.total_votes), 0);
    chk("rst_reject", 32'(bus.reject_cnt), 0);
    chk("rst_sat", 32'(bus.sat_flags), 0);
    chk("rst_leader_idx", 32'(bus.leader_idx), 0);
    chk("rst_leader_tie", 32'(bus.leader_tie), 1);
    chk("rst_ack", 32'(bus.vote_ack), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    reset = 1'b0;
    step();

    // Three separate presses on candidate 1.
    press(5'b00010, 1, 1);
    press(5'b00010, 1, 2);
    press(5'b00010, 1, 3);
    chk("t1_total", 32'(bus.total_votes), 3);
    chk("t1_leader_idx", 32'(bus.leader_idx), 1);
    chk("t1_leader_tie", 32'(bus.leader_tie), 0);

    // Held button counts once; re-press after release counts again.
    bus.vote_valid = 5'b00001;
    ack_exp.push_back(4);
    repeat (10) step();
    bus.vote_valid = '0;
    step();
    chk("t2_total_held", 32'(bus.total_votes), 4);
    press(5'b00001, 1, 5);
    chk("t2_total", 32'(bus.total_votes), 5);

    // Multi-press rejected; narrowing to one button without release does not count.
    bus.vote_valid = 5'b00101;
    step();
    bus.vote_valid = 5'b00001;
    step(); step();
    bus.vote_valid = '0;
    step();
    chk("t3_reject", 32'(bus.reject_cnt), 1);
    chk("t3_total", 32'(bus.total_votes), 5);

    // Saturation on candidate 2: seven counted, eighth rejected.
    for (int k = 0; k < 7; k++) press(5'b00100, 1, 6 + k);
    press(5'b00100, 0, 0);
    chk("t4_sat", 32'(bus.sat_flags), 32'b00100);
    chk("t4_reject", 32'(bus.reject_cnt), 2);
    chk("t4_total", 32'(bus.total_votes), 12);
    chk("t4_leader_idx", 32'(bus.leader_idx), 2);
    chk("t4_leader_tie", 32'(bus.leader_tie), 0);

    // Clear, then build counts {2,5,5,1,0}.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_total", 32'(bus.total_votes), 0);
    chk("clr_reject", 32'(bus.reject_cnt), 0);
    chk("clr_sat", 32'(bus.sat_flags), 0);
    step();
    chk("clr_leader_idx", 32'(bus.leader_idx), 0);
    chk("clr_leader_tie", 32'(bus.leader_tie), 1);
    press(5'b00001, 1, 1);
    press(5'b00001, 1, 2);
    for (int k = 0; k < 5; k++) press(5'b00010, 1, 3 + k);
    for (int k = 0; k < 5; k++) press(5'b00100, 1, 8 + k);
    press(5'b01000, 1, 13);
    chk("t5_leader_idx", 32'(bus.leader_idx), 1);
    chk("t5_leader_tie", 32'(bus.leader_tie), 1);

    // Results mode: back-to-back reads including out-of-range indices.
    bus.mode = 1'b1;
    step();
    rd(3'd2, 5);
    rd(3'd0, 2);
    rd(3'd1, 5);
    rd(3'd3, 1);
    rd(3'd4, 0);
    rd(3'd7, 0);
    bus.rd_req = 1'b0;
    step();
    press(5'b00010, 0, 0);
    chk("t5_mode1_total", 32'(bus.total_votes), 13);
    chk("t5_mode1_reject", 32'(bus.reject_cnt), 0);

    // Read request in voting mode is ignored.
    bus.mode = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_idx = 3'd1;
    step();
    bus.rd_req = 1'b0;
    chk("t5_rd_mode0", 32'(bus.rd_valid), 0);
    step();

    // Clear with simultaneous vote: vote dropped, held button stays locked out.
    bus.clear = 1'b1;
    bus.vote_valid = 5'b00010;
    step();
    bus.clear = 1'b0;
    chk("t6_clr_total", 32'(bus.total_votes), 0);
    chk("t6_clr_ack", 32'(bus.vote_ack), 0);
    chk("t6_clr_reject", 32'(bus.reject_cnt), 0);
    step();
    chk("t6_locked_total", 32'(bus.total_votes), 0);
    bus.vote_valid = '0;
    step();

    // Readout on the same edge as clear returns the pre-clear count.
    press(5'b01000, 1, 1);
    bus.mode = 1'b1;
    bus.clear = 1'b1;
    rd(3'd3, 1);
    bus.rd_req = 1'b0;
    bus.clear = 1'b0;
    chk("t6_rdclr_total", 32'(bus.total_votes), 0);
    bus.mode = 1'b0;
    step();

    // Asynchronous reset while a press is held.
    press(5'b00001, 1, 1);
    bus.vote_valid = 5'b00001;
    ack_exp.push_back(2);
    step();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_total", 32'(bus.total_votes), 0);
    chk("t6_rst_ack", 32'(bus.vote_ack), 0);
    chk("t6_rst_leader_tie", 32'(bus.leader_tie), 1);
    chk("t6_rst_leader_idx", 32'(bus.leader_idx), 0);
    chk("t6_rst_sat", 32'(bus.sat_flags), 0);
    step();
    bus.vote_valid = '0;
    step();
    reset = 1'b0;
    step();
    press(5'b10000, 1, 1);
    chk("t6_post_rst_total", 32'(bus.total_votes), 1);
    step();

    chk("ack_queue_drained", 32'(ack_exp.size()), 0);
    chk("rd_queue_drained", 32'(rd_exp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
